if_fetch_unit: RTL

- Instruction-fetch stage that produces F_pc / F_instr for the IF/ID pipeline register.
- Owns the PC register and a valid/ready request handshake to a variable-latency instruction memory.
- Buffers one fetched instruction until IF/ID accepts it (en=1), honouring stalls.
- Applies branch/jump redirects from D with MIPS delay-slot semantics: the redirect replaces pc+4 after the current F instruction is accepted.

---
 rtl/if_fetch_unit_pkg.sv | 15 +
 rtl/if_fetch_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage constants and state encoding.
// The reset PC and NOP word are also used by the IF/ID register reset.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] IF_RESET_PC  = 32'h0000_3000;
  localparam logic [XLEN-1:0] IF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HAVE  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with a variable-latency imem,
// buffers one instruction for IF/ID and applies delay-slot redirects from D.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic        F_valid
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ibuf_q, ibuf_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_target_q, pend_target_d;

  logic [31:0]  target_al;
  logic         advance;

  assign target_al = {redirect_target[31:2], 2'b00};
  assign advance   = (state_q == HAVE) && en;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC_AL;
      ibuf_q        <= NOP_INSTR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      ibuf_q        <= ibuf_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Next state and next-PC selection
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ibuf_d        = ibuf_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          ibuf_d  = imem_rdata;
          state_d = HAVE;
        end
      end
      HAVE: begin
        if (en) begin
          state_d      = FETCH;
          pend_valid_d = 1'b0;
          if (redirect_valid) begin
            pc_d = target_al;
          end else if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      default: state_d = FETCH;
    endcase

    // Redirect not consumed this cycle waits for the next advance; newest wins.
    if (redirect_valid && !advance) begin
      pend_valid_d  = 1'b1;
      pend_target_d = target_al;
    end
  end

  // Output decode
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    F_pc      = pc_q;
    F_instr   = NOP_INSTR;
    F_valid   = 1'b0;
    case (state_q)
      FETCH: imem_req = 1'b1;
      HAVE: begin
        F_valid = 1'b1;
        F_instr = ibuf_q;
      end
      default: imem_req = 1'b1;
    endcase
  end

endmodule
